// File: rtl/uart_spi_bridge.sv
// Byte-stream to SPI command bridge: opcode FIFO, SPI master with runtime mode, static control lines.
// Define UART_SPI_BRIDGE_READBACK_EN to enable the full-duplex MISO readback stream on rsp_*.
module uart_spi_bridge #(
  parameter int unsigned CLKDIV     = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NCTRL      = 5,
  parameter logic [4:0]  CTRL_RESET = 5'h1F,
  parameter logic [1:0]  MODE_RESET = 2'b11
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [NCTRL-1:0] ctrl,
  output logic             busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
`ifdef UART_SPI_BRIDGE_READBACK_EN
    , StRspWait
`endif
  } state_e;

  // Input FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [7:0]  head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_data;
  end

  state_e            state_q, state_d, state_after;
  logic [4:0]        cnt_q, cnt_d;
  logic [7:0]        tx_q, tx_d;
  logic [3:0]        half_q, half_d;
  logic [DW-1:0]     div_q, div_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [NCTRL-1:0]  ctrl_q, ctrl_d;
  logic              leading, sample;

`ifdef UART_SPI_BRIDGE_READBACK_EN
  logic       rd_q, rd_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
`endif

  assign leading     = !half_q[0];
  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  assign sample      = leading ^ cpha_q;
  assign state_after = (cnt_q != 5'd0) ? StLoad : StIdle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    half_d  = half_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    ctrl_d  = ctrl_q;
    pop     = 1'b0;
`ifdef UART_SPI_BRIDGE_READBACK_EN
    rd_d        = rd_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
`endif
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol_q;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[7:4] == 4'h1 || head[7:4] == 4'h4) begin
            cnt_d   = {1'b0, head[3:0]} + 5'd1;
            state_d = StLoad;
`ifdef UART_SPI_BRIDGE_READBACK_EN
            rd_d = (head[7:4] == 4'h4);
`endif
          end else if (head[7:5] == 3'b001) begin
            ctrl_d = head[NCTRL-1:0];
          end else if (head[7:2] == 6'b010100) begin
            cpol_d = head[1];
            cpha_d = head[0];
            sclk_d = head[1];
          end
        end
      end
      StLoad: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_d    = head;
          mosi_d  = head[7];
          cnt_d   = cnt_q - 5'd1;
          half_d  = '0;
          div_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          half_d = half_q + 4'd1;
          sclk_d = leading ? !cpol_q : cpol_q;
          if (sample) begin
`ifdef UART_SPI_BRIDGE_READBACK_EN
            rx_d = {rx_q[6:0], spi_miso};
`endif
          end else if (cpha_q) begin
            mosi_d = tx_q[3'd7 - half_q[3:1]];
          end else if (half_q[3:1] != 3'd7) begin
            mosi_d = tx_q[3'd6 - half_q[3:1]];
          end
          if (half_q == 4'd15) begin
            state_d = state_after;
`ifdef UART_SPI_BRIDGE_READBACK_EN
            if (rd_q) begin
              if (!rsp_valid_q || rsp_ready) begin
                rsp_data_d  = rx_d;
                rsp_valid_d = 1'b1;
              end else begin
                state_d = StRspWait;
              end
            end
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef UART_SPI_BRIDGE_READBACK_EN
      StRspWait: begin
        if (rsp_ready) begin
          rsp_data_d  = rx_q;
          rsp_valid_d = 1'b1;
          state_d     = state_after;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      half_q  <= '0;
      div_q   <= '0;
      sclk_q  <= MODE_RESET[1];
      mosi_q  <= 1'b1;
      cpol_q  <= MODE_RESET[1];
      cpha_q  <= MODE_RESET[0];
      ctrl_q  <= CTRL_RESET[NCTRL-1:0];
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      half_q  <= half_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef UART_SPI_BRIDGE_READBACK_EN
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_q        <= 1'b0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
`else
  logic unused_rsp;
  assign unused_rsp = rsp_ready ^ spi_miso;
  assign rsp_data   = 8'h00;
  assign rsp_valid  = 1'b0;
`endif

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign ctrl     = ctrl_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Randomised scoreboard bench for uart_spi_bridge: a bus-level SPI slave/monitor and rsp/ctrl
// monitors compare against expectations queued when each command is issued.
module tb_uart_spi_bridge;

  localparam int unsigned CLKDIV     = 2;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned NCTRL      = 5;
  localparam logic [4:0]  CTRL_RESET = 5'h1F;
  localparam logic [1:0]  MODE_RESET = 2'b11;
`ifdef UART_SPI_BRIDGE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetq = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       rsp_data;
  logic             rsp_valid;
  logic             rdy = 1'b0;
  logic             spi_sclk, spi_mosi;
  logic             miso = 1'b1;
  logic [NCTRL-1:0] ctrl;
  logic             busy;

  uart_spi_bridge #(
    .CLKDIV(CLKDIV), .FIFO_DEPTH(FIFO_DEPTH), .NCTRL(NCTRL),
    .CTRL_RESET(CTRL_RESET), .MODE_RESET(MODE_RESET)
  ) dut (
    .clk(clk), .resetq(resetq), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rdy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(miso), .ctrl(ctrl), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard queues and reference state
  logic [7:0]       mosi_exp[$];
  logic [7:0]       miso_q[$];
  logic [7:0]       rsp_exp[$];
  logic [NCTRL-1:0] ctrl_exp[$];
  logic [7:0]       pl_q[$];
  logic [7:0]       sl_q[$];
  logic [NCTRL-1:0] model_ctrl = CTRL_RESET[NCTRL-1:0];
  bit               cur_cpol = MODE_RESET[1];
  bit               cur_cpha = MODE_RESET[0];
  bit               mon_hold = 1'b1;
  int               rdy_mode = 0;
  int               stall_cycles = 0;
  int               sclk_edges = 0;
  int               bits = 0;
  int               rsp_bad = 0;

  // Monitor: SPI slave + MOSI checker, ctrl and rsp checkers, rsp_ready driver.
  initial begin
    logic             sclk_prev, mosi_prev, lead;
    logic [NCTRL-1:0] ctrl_prev;
    logic [7:0]       mon_sh, sl_byte, e;
    int               byte_edges, gap, sl_j;
    bit               need_load;
    sclk_prev = 1'b0; mosi_prev = 1'b0; ctrl_prev = '0; mon_sh = '0; sl_byte = '0;
    byte_edges = 0; gap = 0; sl_j = 0; need_load = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mon_hold) begin
        sclk_prev = spi_sclk; mosi_prev = spi_mosi; ctrl_prev = ctrl;
        byte_edges = 0; bits = 0; gap = 0; sl_j = 0; need_load = 1'b1;
      end else begin
        gap++;
        if (spi_sclk !== sclk_prev) begin
          sclk_edges++;
          if (byte_edges > 0) check("sclk_half_period", gap, CLKDIV);
          gap = 0;
          lead = (sclk_prev == cur_cpol);
          if (lead ^ cur_cpha) begin
            mon_sh = {mon_sh[6:0], mosi_prev};
            bits++;
          end else begin
            if (cur_cpha) miso = sl_byte[7 - sl_j];
            else if (sl_j < 7) miso = sl_byte[6 - sl_j];
            sl_j++;
          end
          byte_edges++;
          if (byte_edges == 16) begin
            if (mosi_exp.size() == 0) begin
              $display("FAIL spi_byte_unexpected: got 0x%0h, none expected", mon_sh);
              n_checks++;
            end else begin
              e = mosi_exp.pop_front();
              check("spi_mosi_byte", mon_sh, e);
            end
            byte_edges = 0; bits = 0; sl_j = 0; need_load = 1'b1;
          end
        end
        sclk_prev = spi_sclk;
        mosi_prev = spi_mosi;
        if (need_load && miso_q.size() > 0) begin
          sl_byte = miso_q.pop_front();
          miso = sl_byte[7];
          need_load = 1'b0;
          sl_j = 0;
        end
        if (ctrl !== ctrl_prev) begin
          if (ctrl_exp.size() == 0) begin
            $display("FAIL ctrl_unexpected: got 0x%0h, none expected", ctrl);
            n_checks++;
          end else begin
            check("ctrl_value", ctrl, ctrl_exp.pop_front());
          end
          ctrl_prev = ctrl;
        end
        if (RB) begin
          if (rsp_valid && rdy) begin
            if (rsp_exp.size() == 0) begin
              $display("FAIL rsp_unexpected: got 0x%0h, none expected", rsp_data);
              n_checks++;
            end else begin
              check("rsp_byte", rsp_data, rsp_exp.pop_front());
            end
          end
        end else if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
          rsp_bad++;
        end
      end
      case (rdy_mode)
        1:       rdy = 1'b0;
        2:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic push(input logic [7:0] b);
    int t;
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
      stall_cycles++;
    end
    if (!in_ready) fail("push_timeout");
  endtask

  task automatic push_end;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Transfer of pl_q; slave returns sl_q (random where sl_q is short).
  task automatic xfer(input bit rd);
    logic [7:0] op, m;
    int n;
    n = pl_q.size();
    for (int i = 0; i < n; i++) begin
      m = (i < sl_q.size()) ? sl_q[i] : 8'($urandom);
      mosi_exp.push_back(pl_q[i]);
      miso_q.push_back(m);
      if (rd && RB) rsp_exp.push_back(m);
    end
    op = rd ? 8'h40 : 8'h10;
    op[3:0] = 4'(n - 1);
    push(op);
    for (int i = 0; i < n; i++) push(pl_q[i]);
    pl_q.delete();
    sl_q.delete();
  endtask

  task automatic rand_payload(input int n);
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  task automatic ctrl_cmd(input logic [4:0] d);
    logic [NCTRL-1:0] v;
    v = d[NCTRL-1:0];
    if (v != model_ctrl) ctrl_exp.push_back(v);
    model_ctrl = v;
    push({3'b001, d});
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || rsp_valid) && t < 20000);
    if (busy || rsp_valid) fail("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mode(input bit p, input bit q);
    wait_idle();
    mon_hold = 1'b1;
    push({6'b010100, p, q});
    push_end();
    wait_idle();
    cur_cpol = p;
    cur_cpha = q;
    check("mode_sclk_idle", spi_sclk, p);
    @(negedge clk);
    mon_hold = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r, t;
    logic [7:0] s0;
    logic [7:0] junk [8];
    junk = '{8'h00, 8'h0F, 8'h54, 8'h5F, 8'h6A, 8'h80, 8'hC3, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_sclk", spi_sclk, MODE_RESET[1]);
    check("rst_mosi", spi_mosi, 1'b1);
    check("rst_ctrl", ctrl, CTRL_RESET[NCTRL-1:0]);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    resetq = 1'b1;
    @(negedge clk);
    mon_hold = 1'b0;

    // Single write byte in mode 11
    e0 = sclk_edges;
    pl_q.push_back(8'hA5);
    xfer(1'b0);
    push_end();
    wait_idle();
    check("t1_sclk_edges", sclk_edges - e0, 16);
    check("t1_sclk_idle", spi_sclk, 1'b1);

    // ctrl write timing
    e0 = sclk_edges;
    ctrl_exp.push_back(5'b11010);
    model_ctrl = 5'b11010;
    @(negedge clk);
    in_data = 8'h3A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_ctrl_before_pop", ctrl, CTRL_RESET[NCTRL-1:0]);
    @(negedge clk);
    check("t2_ctrl_after_pop", ctrl, 5'b11010);
    wait_idle();
    check("t2_no_sclk", sclk_edges - e0, 0);

    // Readback in mode 00 with a looped-back slave
    set_mode(1'b0, 1'b0);
    pl_q.push_back(8'h3C); pl_q.push_back(8'hFF);
    sl_q.push_back(8'h3C); sl_q.push_back(8'hFF);
    xfer(1'b1);
    push_end();
    wait_idle();
    check("t3_sclk_idle", spi_sclk, 1'b0);

`ifdef UART_SPI_BRIDGE_READBACK_EN
    // Back-pressured readback stalls in the wait state
    rdy_mode = 1;
    rand_payload(2);
    s0 = 8'($urandom);
    sl_q.push_back(s0);
    xfer(1'b1);
    push_end();
    t = 0;
    while (!rsp_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t4_rsp_valid_seen", rsp_valid, 1'b1);
    check("t4_rsp_first", rsp_data, s0);
    repeat (60) @(negedge clk);
    e0 = sclk_edges;
    repeat (40) @(negedge clk);
    check("t4_sclk_frozen", sclk_edges - e0, 0);
    check("t4_sclk_at_cpol", spi_sclk, 1'b0);
    check("t4_busy_stalled", busy, 1'b1);
    check("t4_rsp_held", rsp_data, s0);
    rdy_mode = 2;
    wait_idle();
    rdy_mode = 0;
`endif

    // Burst of 20 bytes against a slow transfer
    stall_cycles = 0;
    rand_payload(16);
    xfer(1'b0);
    rand_payload(1);
    xfer(1'b0);
    ctrl_cmd(5'($urandom));
    push_end();
    wait_idle();
    check("t5_in_ready_low_seen", (stall_cycles > 0), 1'b1);

    // Randomised command streams in every mode
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          rand_payload((r == 0) ? $urandom_range(1, 16) : $urandom_range(1, 4));
          xfer(1'b0);
        end else if (r < 7) begin
          rand_payload($urandom_range(1, 4));
          xfer(1'b1);
        end else if (r < 9) begin
          ctrl_cmd(5'($urandom));
        end else begin
          push(junk[$urandom_range(0, 7)]);
        end
      end
      push_end();
      wait_idle();
    end

    // Reset in the middle of a byte
    set_mode(1'b0, 1'b1);
    rand_payload(4);
    xfer(1'b0);
    push_end();
    t = 0;
    while (bits < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t6_reached_bit3", (bits >= 3), 1'b1);
    mon_hold = 1'b1;
    resetq = 1'b0;
    #1;
    check("t6_rst_sclk", spi_sclk, MODE_RESET[1]);
    check("t6_rst_mosi", spi_mosi, 1'b1);
    check("t6_rst_ctrl", ctrl, CTRL_RESET[NCTRL-1:0]);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b1);
    check("t6_rst_rsp_valid", rsp_valid, 1'b0);
    mosi_exp.delete();
    miso_q.delete();
    rsp_exp.delete();
    ctrl_exp.delete();
    model_ctrl = CTRL_RESET[NCTRL-1:0];
    cur_cpol = MODE_RESET[1];
    cur_cpha = MODE_RESET[0];
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    mon_hold = 1'b0;
    pl_q.push_back(8'h81);
    xfer(1'b0);
    push_end();
    wait_idle();
    check("t6_sclk_idle", spi_sclk, 1'b1);

    check("end_mosi_queue_empty", mosi_exp.size(), 0);
    check("end_rsp_queue_empty", rsp_exp.size(), 0);
    check("end_ctrl_queue_empty", ctrl_exp.size(), 0);
    if (!RB) check("rsp_tied_zero", rsp_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
